// File: rtl/abuf_reader_if.sv
// Playback-side bundle of abuf_reader: control in, abuf read port, DSP sample output, interrupt.
// master = the reader itself, slave = register bank / abuf / dsp_unit side.
interface abuf_reader_if #(
    parameter int BUFFER_SIZE = 32,
    parameter int DATA_W      = 24,
    parameter int AW          = $clog2(4 * BUFFER_SIZE)
);
    logic              play;
    logic [31:0]       clk_div;
    logic [AW-1:0]     rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] audio0;
    logic [DATA_W-1:0] audio1;
    logic              tick;
    logic              buf_sel;
    logic              irq;
    logic              irqack;
    logic              irq_err;

    modport master (
        input  play, clk_div, rd_data, irqack,
        output rd_addr, audio0, audio1, tick, buf_sel, irq, irq_err
    );

    modport slave (
        output play, clk_div, rd_data, irqack,
        input  rd_addr, audio0, audio1, tick, buf_sel, irq, irq_err
    );
endinterface

// File: rtl/abuf_reader.sv
// Ping-pong abuf playback at sample rate; first tick div_q+2 cycles after play rise, then every div_q.
// No backpressure: rd_data is combinational, dsp_unit must accept every tick.
module abuf_reader #(
    parameter int BUFFER_SIZE = 32,
    parameter int DATA_W      = 24,
    parameter int AW          = $clog2(4 * BUFFER_SIZE)
) (
    input  logic          clk,
    input  logic          rst,
    abuf_reader_if.master bus
);
    localparam int IW = $clog2(BUFFER_SIZE);

    typedef enum logic [1:0] {IDLE, FETCH_L, FETCH_R, OUT} state_t;

    state_t            state_q, state_d;
    logic [31:0]       div_q, cnt_q;
    logic              play_q, tc, play_rise;
    logic [IW-1:0]     idx_q;
    logic              buf_sel_q, irq_q, irq_err_q, tick_q;
    logic [AW-1:0]     rd_addr_q;
    logic [DATA_W-1:0] cap_l, cap_r, audio0_q, audio1_q;

    assign tc        = (cnt_q == div_q - 32'd1);
    assign play_rise = bus.play && !play_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (tc) state_d = FETCH_L;
            FETCH_L: state_d = FETCH_R;
            FETCH_R: state_d = OUT;
            OUT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (!bus.play) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            play_q    <= 1'b0;
            div_q     <= 32'd4;
            cnt_q     <= '0;
            idx_q     <= '0;
            buf_sel_q <= 1'b0;
            irq_q     <= 1'b0;
            irq_err_q <= 1'b0;
            tick_q    <= 1'b0;
            rd_addr_q <= '0;
            cap_l     <= '0;
            cap_r     <= '0;
            audio0_q  <= '0;
            audio1_q  <= '0;
        end else begin
            play_q <= bus.play;
            tick_q <= 1'b0;
            if (play_rise) begin
                // Floor of 4 keeps the 3-cycle fetch sequence back in IDLE before the next TC.
                div_q     <= (bus.clk_div < 32'd4) ? 32'd4 : bus.clk_div;
                irq_err_q <= 1'b0;
            end
            if (bus.irqack) irq_q <= 1'b0;

            if (!bus.play) begin
                cnt_q     <= '0;
                idx_q     <= '0;
                buf_sel_q <= 1'b0;
                audio0_q  <= '0;
                audio1_q  <= '0;
            end else begin
                cnt_q <= tc ? 32'd0 : cnt_q + 32'd1;
                case (state_q)
                    IDLE: if (tc) rd_addr_q <= {buf_sel_q, idx_q, 1'b0};
                    FETCH_L: begin
                        cap_l     <= bus.rd_data;
                        rd_addr_q <= rd_addr_q + AW'(1);
                    end
                    FETCH_R: cap_r <= bus.rd_data;
                    OUT: begin
                        audio0_q <= cap_l;
                        audio1_q <= cap_r;
                        tick_q   <= 1'b1;
                        idx_q    <= idx_q + IW'(1);
                        // Buffer fully consumed; set is ordered after the ack so it wins a tie.
                        if (idx_q == IW'(BUFFER_SIZE - 1)) begin
                            buf_sel_q <= ~buf_sel_q;
                            irq_q     <= 1'b1;
                            if (irq_q) irq_err_q <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.rd_addr = rd_addr_q;
    assign bus.audio0  = audio0_q;
    assign bus.audio1  = audio1_q;
    assign bus.tick    = tick_q;
    assign bus.buf_sel = buf_sel_q;
    assign bus.irq     = irq_q;
    assign bus.irq_err = irq_err_q;
endmodule
